pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Merges Hazard-unit requests (StalF, StalD, FlushD, FlushE) with two multi-cycle stall sources: a fixed-latency multiply/divide unit (MDV) in EX and a data memory with a ready handshake in MEM. Drives the load enables and synchronous clears of the PC and every pipeline register. Also keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

## Interface
- MDU_LAT, 4: total EX residency of an MDV instruction in cycles; legal range ≥2.
- MEM_TIMEOUT, 8: consecutive memory-stall cycles before MemErr sets; legal range ≥1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- StalF, StalD, FlushD, FlushE  in  1 each  Hazard-unit requests.
- MdvStartE  in  1  the EX-stage instruction is a mul/div.
- MemReqM  in  1  the MEM-stage instruction is a load or store.
- MemReadyM  in  1  data memory completes the access this cycle.
- EnF, EnD, EnE, EnM  out  1 each  load enables for PC, IF/ID, ID/EX and EX/MEM.
- ClrD, ClrE, ClrM, ClrW  out  1 each  synchronous bubble insert into IF/ID, ID/EX, EX/MEM and MEM/WB. MEM/WB is always enabled.
- MdvGoE  out  1  one-cycle pulse that launches the MDV unit.
- MdvDoneE  out  1  one-cycle pulse when the MDV result is valid.
- MemErr  out  1  sticky memory-timeout flag.
- StallCycles  out  16  saturating count of cycles with EnF=0.

## Operation
- Registered state:
  - FSM with states RUN and MDV.
  - cnt: MDV countdown, clog2(MDU_LAT) bits.
  - wcnt: memory-wait counter, saturates at MEM_TIMEOUT.
  - MemErr and StallCycles.
- memstall = MemReqM & ~MemReadyM. It is combinational and evaluated only in RUN.
- RUN, memstall=1. Priority 1.
  - Outputs: EnF=EnD=EnE=EnM=0, ClrW=1, ClrD=ClrE=ClrM=0.
  - The Hazard inputs are ignored.
  - MdvStartE is deferred: no MdvGoE, no state change.
- RUN, memstall=0, MdvStartE=1.
  - Outputs: MdvGoE=1, EnF=EnD=EnE=0, EnM=1, ClrM=1, all other Clr=0.
  - Next state MDV, cnt←MDU_LAT-2.
- RUN, otherwise (normal flow).
  - EnF=~StalF, EnD=~StalD, EnE=EnM=1.
  - ClrD=FlushD, ClrE=FlushE, ClrM=ClrW=0.
- MDV, cnt≠0.
  - Outputs: EnF=EnD=EnE=0, EnM=1, ClrM=1, ClrD=ClrE=ClrW=0.
  - Hazard inputs ignored; cnt←cnt-1.
- MDV, cnt=0.
  - MdvDoneE=1; outputs follow the normal-flow RUN rule, including Hazard passthrough.
  - MdvStartE is ignored this cycle because it still refers to the finishing instruction.
  - Next state RUN.
- wcnt: +1 on each RUN cycle with memstall=1, saturating at MEM_TIMEOUT; cleared to 0 on any other cycle.
- MemErr: set at the clock edge where wcnt reaches MEM_TIMEOUT. It stays set until rst_n asserts. The stall continues after the flag sets; there is no abort.
- StallCycles: +1 at every edge where EnF=0; holds at 16'hFFFF.

## Timing
- Reset (rst_n=0, async):
  - FSM←RUN; cnt, wcnt, StallCycles←0; MemErr←0.
  - While rst_n=0, all En*, Clr*, MdvGoE and MdvDoneE are forced to 0.
- Reset release: first edge after rst_n rises runs in RUN.
- MDV launched at cycle t:
  - MdvGoE at t; MdvDoneE at t+MDU_LAT-1.
  - ID/EX reloads at the t+MDU_LAT-1 edge.
  - EX/MEM receives MDU_LAT-1 bubbles.
- Memory stall: zero-cycle response; pipeline advances in the same cycle MemReadyM=1.
- All outputs except MemErr and StallCycles are combinational from state and inputs. MemErr and StallCycles are registered.
- Reset asserted during MDV aborts it with no MdvDoneE; a pending MemErr is also cleared.

## Test plan
- Reset and normal flow: rst_n=0 → all outputs 0. Release with idle inputs → EnF=EnD=EnE=EnM=1, Clr*=0, StallCycles=0.
- Hazard passthrough:
  - StalF=StalD=1, FlushE=1 → EnF=EnD=0, ClrE=1, StallCycles +1 per cycle.
  - FlushD=FlushE=1 → ClrD=ClrE=1.
- MDV with MDU_LAT=4, MdvStartE held high over cycles t..t+4:
  - MdvGoE at t; EnE=0 and ClrM=1 at t..t+2; MdvDoneE=1 and EnE=1 at t+3.
  - No retrigger at t+3; MdvGoE again at t+4.
- Memory stall: MemReqM=1, MemReadyM=0 for 3 cycles with FlushE=1 and MdvStartE=1 → EnF..EnM=0, ClrW=1, ClrE=0, no MdvGoE, StallCycles=3. Then MemReadyM=1 → MdvGoE=1 that cycle.
- Timeout, MEM_TIMEOUT=8: MemReadyM=0 for 8 cycles → MemErr=1 after the 8th edge, still 1 after MemReadyM=1. Then rst_n=0 → MemErr=0.
- Reset mid-MDV: rst_n=0 at t+1 after MdvGoE → no MdvDoneE is ever produced. After release, state is RUN and MdvStartE=1 relaunches.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Central stall/flush sequencer for the 5-stage pipeline. It merges the
// hazard unit's stall/flush requests with two multi-cycle stall sources:
//   - a fixed-latency multiply/divide unit (MDV) sitting in EX
//   - a data memory with a ready handshake sitting in MEM
// From these it produces the load enables and synchronous clears of the PC
// and every pipeline register. It also keeps a saturating count of stalled
// fetch cycles and a sticky memory-timeout flag.
//
// Parameters
//   MDU_LAT      total EX residency of a mul/div instruction (>= 2)
//   MEM_TIMEOUT  consecutive memory-stall cycles before MemErr sets (>= 1)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   StalF/StalD  hazard-unit stall requests for PC and IF/ID
//   FlushD/E     hazard-unit flush requests for IF/ID and ID/EX
//   MdvStartE    EX-stage instruction is a mul/div
//   MemReqM      MEM-stage instruction is a load or store
//   MemReadyM    data memory completes the access this cycle
//   EnF..EnM     load enables for PC, IF/ID, ID/EX, EX/MEM
//   ClrD..ClrW   synchronous bubble insert for IF/ID, ID/EX, EX/MEM, MEM/WB
//   MdvGoE       one-cycle launch pulse for the MDV unit
//   MdvDoneE     one-cycle pulse when the MDV result is valid
//   MemErr       sticky memory-timeout flag (registered)
//   StallCycles  saturating count of cycles with EnF=0 (registered)
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl #(
  parameter int MDU_LAT     = 4,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StalF,
  input  logic        StalD,
  input  logic        FlushD,
  input  logic        FlushE,
  input  logic        MdvStartE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        EnF,
  output logic        EnD,
  output logic        EnE,
  output logic        EnM,
  output logic        ClrD,
  output logic        ClrE,
  output logic        ClrM,
  output logic        ClrW,
  output logic        MdvGoE,
  output logic        MdvDoneE,
  output logic        MemErr,
  output logic [15:0] StallCycles
);

  localparam int CW = $clog2(MDU_LAT);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MDU_LAT - 2);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MDV = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cntNext;
  logic [WW-1:0] r_wcnt;
  logic [WW-1:0] w_wcntNext;
  logic [15:0]   r_stallCycles;
  logic          r_memErr;
  logic          w_memStall;

  assign w_memStall = MemReqM & ~MemReadyM;

  // State, MDV countdown, memory-wait counter and the two status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_cnt         <= '0;
      r_wcnt        <= '0;
      r_stallCycles <= '0;
      r_memErr      <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_cntNext;
      r_wcnt  <= w_wcntNext;
      if (w_wcntNext == WAIT_MAX) begin
        r_memErr <= 1'b1;
      end
      if (!EnF && (r_stallCycles != 16'hFFFF)) begin
        r_stallCycles <= r_stallCycles + 16'd1;
      end
    end
  end

  // The wait counter only runs while a memory stall is actually in control;
  // any cycle spent in MDV or flowing normally restarts it.
  always_comb begin
    w_wcntNext = '0;
    if ((r_state == ST_RUN) && w_memStall) begin
      w_wcntNext = (r_wcnt == WAIT_MAX) ? r_wcnt : (r_wcnt + WW'(1));
    end
  end

  // Next-state and combinational outputs. Everything is held at zero while
  // reset is asserted so no register loads or clears during reset.
  always_comb begin
    w_nextState = r_state;
    w_cntNext   = r_cnt;
    EnF         = 1'b0;
    EnD         = 1'b0;
    EnE         = 1'b0;
    EnM         = 1'b0;
    ClrD        = 1'b0;
    ClrE        = 1'b0;
    ClrM        = 1'b0;
    ClrW        = 1'b0;
    MdvGoE      = 1'b0;
    MdvDoneE    = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        ST_RUN: begin
          if (w_memStall) begin
            // Memory stall wins: freeze everything up to EX/MEM and drain
            // a bubble into WB. A pending mul/div start simply waits.
            ClrW = 1'b1;
          end else if (MdvStartE) begin
            MdvGoE      = 1'b1;
            EnM         = 1'b1;
            ClrM        = 1'b1;
            w_nextState = ST_MDV;
            w_cntNext   = CNT_INIT;
          end else begin
            EnF  = ~StalF;
            EnD  = ~StalD;
            EnE  = 1'b1;
            EnM  = 1'b1;
            ClrD = FlushD;
            ClrE = FlushE;
          end
        end
        ST_MDV: begin
          if (r_cnt != '0) begin
            EnM       = 1'b1;
            ClrM      = 1'b1;
            w_cntNext = r_cnt - CW'(1);
          end else begin
            // Final MDV cycle: MdvStartE still describes the finishing
            // instruction, so it must not relaunch the unit here.
            MdvDoneE    = 1'b1;
            EnF         = ~StalF;
            EnD         = ~StalD;
            EnE         = 1'b1;
            EnM         = 1'b1;
            ClrD        = FlushD;
            ClrE        = FlushE;
            w_nextState = ST_RUN;
          end
        end
        default: begin
          w_nextState = ST_RUN;
        end
      endcase
    end
  end

  assign MemErr      = r_memErr;
  assign StallCycles = r_stallCycles;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//
// Self-checking bench for pipeline_stall_ctrl. A behavioural model tracks
// "cycles left until the mul/div result", "consecutive stalled memory
// cycles", the sticky error and the stall count as plain integers, and
// derives the expected enables/clears from the priority rules directly.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

  localparam int MDU_LAT     = 4;
  localparam int MEM_TIMEOUT = 8;

  logic        clk;
  logic        rst_n;
  logic        StalF, StalD, FlushD, FlushE;
  logic        MdvStartE, MemReqM, MemReadyM;
  logic        EnF, EnD, EnE, EnM;
  logic        ClrD, ClrE, ClrM, ClrW;
  logic        MdvGoE, MdvDoneE, MemErr;
  logic [15:0] StallCycles;

  int nCompared;
  int nMismatched;

  // Reference model state
  int mdvLeft;
  int memWait;
  bit mErr;
  int stalls;

  pipeline_stall_ctrl #(
    .MDU_LAT(MDU_LAT),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .StalF(StalF),
    .StalD(StalD),
    .FlushD(FlushD),
    .FlushE(FlushE),
    .MdvStartE(MdvStartE),
    .MemReqM(MemReqM),
    .MemReadyM(MemReadyM),
    .EnF(EnF),
    .EnD(EnD),
    .EnE(EnE),
    .EnM(EnM),
    .ClrD(ClrD),
    .ClrE(ClrE),
    .ClrM(ClrM),
    .ClrW(ClrW),
    .MdvGoE(MdvGoE),
    .MdvDoneE(MdvDoneE),
    .MemErr(MemErr),
    .StallCycles(StallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bit order: EnF EnD EnE EnM ClrD ClrE ClrM ClrW MdvGoE MdvDoneE
  function automatic logic [9:0] dutOuts();
    return {EnF, EnD, EnE, EnM, ClrD, ClrE, ClrM, ClrW, MdvGoE, MdvDoneE};
  endfunction

  function automatic logic [26:0] dutSnap();
    return {dutOuts(), MemErr, StallCycles};
  endfunction

  // Expected combinational outputs from the rules: an MDV in flight owns
  // the pipe, then a memory stall, then a new MDV launch, then normal flow.
  function automatic logic [9:0] modelOutputs();
    logic [9:0] normal;
    normal = {~StalF, ~StalD, 1'b1, 1'b1, FlushD, FlushE, 4'b0000};
    if (!rst_n)                     return 10'b0;
    if (mdvLeft > 1)                return 10'b0001001000;
    if (mdvLeft == 1)               return normal | 10'b0000000001;
    if (MemReqM && !MemReadyM)      return 10'b0000000100;
    if (MdvStartE)                  return 10'b0001001010;
    return normal;
  endfunction

  function automatic logic [26:0] modelSnap();
    return {modelOutputs(), mErr, 16'(stalls)};
  endfunction

  task automatic modelReset();
    mdvLeft = 0;
    memWait = 0;
    mErr    = 1'b0;
    stalls  = 0;
  endtask

  // Advance the model across one rising edge using the inputs held there.
  task automatic modelAdvance();
    logic [9:0] o;
    bit         idle;
    if (!rst_n) begin
      modelReset();
      return;
    end
    o    = modelOutputs();
    idle = (mdvLeft == 0);
    if (!o[9] && stalls < 65535) stalls++;
    if (idle && MemReqM && !MemReadyM) begin
      if (memWait < MEM_TIMEOUT) memWait++;
    end else begin
      memWait = 0;
    end
    if (memWait == MEM_TIMEOUT) mErr = 1'b1;
    if (mdvLeft > 0)  mdvLeft--;
    else if (o[1])    mdvLeft = MDU_LAT - 1;
  endtask

  // {StalF, StalD, FlushD, FlushE, MdvStartE, MemReqM, MemReadyM}
  task automatic applyStimulus(input logic [6:0] v);
    {StalF, StalD, FlushD, FlushE, MdvStartE, MemReqM, MemReadyM} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    modelAdvance();
    @(negedge clk);
  endtask

  // Assert reset for one edge with idle inputs, then release.
  task automatic doReset();
    @(negedge clk);
    applyStimulus(7'b0);
    rst_n = 1'b0;
    modelReset();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    applyStimulus(7'b1111111);
    rst_n = 1'b0;
    modelReset();
    #1;
    nCompared++;
    if (dutSnap() !== 27'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_hold: got %h want %h", dutSnap(), 27'b0);
    end
    tick();
    applyStimulus(7'b0);
    rst_n = 1'b1;
    #1;
    nCompared++;
    if (dutSnap() !== {10'b1111000000, 1'b0, 16'd0}) begin
      nMismatched++;
      $display("[TB] FAIL reset_release: got %h want %h", dutSnap(), {10'b1111000000, 1'b0, 16'd0});
    end
    tick();
  endtask

  task automatic test_hazard();
    doReset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(7'b1101000);
      #1;
      nCompared++;
      if (dutSnap() !== {10'b0011010000, 1'b0, 16'(k)}) begin
        nMismatched++;
        $display("[TB] FAIL hazard_stall c%0d: got %h want %h", k, dutSnap(), {10'b0011010000, 1'b0, 16'(k)});
      end
      tick();
    end
    applyStimulus(7'b0011000);
    #1;
    nCompared++;
    if (dutSnap() !== {10'b1111110000, 1'b0, 16'd3}) begin
      nMismatched++;
      $display("[TB] FAIL hazard_flush: got %h want %h", dutSnap(), {10'b1111110000, 1'b0, 16'd3});
    end
    tick();
  endtask

  task automatic test_mdv();
    logic [3:0] want [5];
    logic [3:0] got;
    // {EnE, ClrM, MdvGoE, MdvDoneE} for cycles t..t+4 with MdvStartE high
    want[0] = 4'b0110;
    want[1] = 4'b0100;
    want[2] = 4'b0100;
    want[3] = 4'b1001;
    want[4] = 4'b0110;
    doReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(7'b0000100);
      #1;
      got = {EnE, ClrM, MdvGoE, MdvDoneE};
      nCompared++;
      if (got !== want[k]) begin
        nMismatched++;
        $display("[TB] FAIL mdv_seq t+%0d: got %b want %b", k, got, want[k]);
      end
      nCompared++;
      if (dutSnap() !== modelSnap()) begin
        nMismatched++;
        $display("[TB] FAIL mdv_model t+%0d: got %h want %h", k, dutSnap(), modelSnap());
      end
      tick();
    end
  endtask

  task automatic test_memstall();
    doReset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(7'b0001110);
      #1;
      nCompared++;
      if (dutSnap() !== {10'b0000000100, 1'b0, 16'(k)}) begin
        nMismatched++;
        $display("[TB] FAIL memstall c%0d: got %h want %h", k, dutSnap(), {10'b0000000100, 1'b0, 16'(k)});
      end
      tick();
    end
    applyStimulus(7'b0001111);
    #1;
    nCompared++;
    if (dutSnap() !== {10'b0001001010, 1'b0, 16'd3}) begin
      nMismatched++;
      $display("[TB] FAIL memstall_release: got %h want %h", dutSnap(), {10'b0001001010, 1'b0, 16'd3});
    end
    tick();
  endtask

  task automatic test_timeout();
    doReset();
    for (int k = 0; k < MEM_TIMEOUT; k++) begin
      applyStimulus(7'b0000010);
      #1;
      nCompared++;
      if (MemErr !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL timeout_early c%0d: got %b want 0", k, MemErr);
      end
      tick();
    end
    applyStimulus(7'b0000011);
    #1;
    nCompared++;
    if (MemErr !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL timeout_set: got %b want 1", MemErr);
    end
    tick();
    applyStimulus(7'b0);
    #1;
    nCompared++;
    if (dutSnap() !== modelSnap() || MemErr !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL timeout_sticky: got %h want %h", dutSnap(), modelSnap());
    end
    rst_n = 1'b0;
    modelReset();
    #1;
    nCompared++;
    if (MemErr !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL timeout_clear: got %b want 0", MemErr);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_mdv();
    int doneSeen;
    doneSeen = 0;
    doReset();
    applyStimulus(7'b0000100);
    #1;
    nCompared++;
    if (MdvGoE !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL midreset_go: got %b want 1", MdvGoE);
    end
    tick();
    applyStimulus(7'b0);
    rst_n = 1'b0;
    modelReset();
    #1;
    if (MdvDoneE === 1'b1) doneSeen++;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < MDU_LAT + 2; k++) begin
      #1;
      if (MdvDoneE === 1'b1) doneSeen++;
      tick();
    end
    nCompared++;
    if (doneSeen !== 0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_nodone: got %0d pulses want 0", doneSeen);
    end
    applyStimulus(7'b0000100);
    #1;
    nCompared++;
    if (dutSnap() !== {10'b0001001010, 1'b0, 16'(stalls)}) begin
      nMismatched++;
      $display("[TB] FAIL midreset_relaunch: got %h want %h", dutSnap(), {10'b0001001010, 1'b0, 16'(stalls)});
    end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] v;
    doReset();
    for (int k = 0; k < 600; k++) begin
      v[6] = ($urandom_range(0, 3) == 0);
      v[5] = ($urandom_range(0, 3) == 0);
      v[4] = ($urandom_range(0, 3) == 0);
      v[3] = ($urandom_range(0, 3) == 0);
      v[2] = ($urandom_range(0, 4) == 0);
      v[1] = ($urandom_range(0, 2) == 0);
      v[0] = ($urandom_range(0, 5) != 0) ? (k % 40 < 30) : 1'b1;
      applyStimulus(v);
      if ($urandom_range(0, 99) < 2) begin
        rst_n = 1'b0;
        modelReset();
      end else begin
        rst_n = 1'b1;
      end
      #1;
      nCompared++;
      if (dutSnap() !== modelSnap()) begin
        nMismatched++;
        $display("[TB] FAIL random c%0d: got %h want %h", k, dutSnap(), modelSnap());
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst_n       = 1'b1;
    applyStimulus(7'b0);
    modelReset();
    $display("[TB] starting pipeline_stall_ctrl bench");
    test_reset();
    test_hazard();
    test_mdv();
    test_memstall();
    test_timeout();
    test_reset_mid_mdv();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
